// File: rtl/onehot_dec_alloc_if.sv
// Bundle of decode, allocate and free signals shared by onehot_dec_alloc and
// whatever sits in front of it.
//
// Handshake semantics: there is no ready/backpressure on any path. dec_en,
// alloc_req and free_vld are single-cycle request strobes sampled at the
// rising clock edge. For allocation, alloc_gnt acts as the same-cycle
// acceptance of alloc_req: a request is consumed only in a cycle where
// alloc_req && alloc_gnt, and the slot named by alloc_idx/alloc_onehot
// becomes busy at that edge. A request without grant is simply dropped; the
// requester re-asserts in a later cycle.
interface onehot_dec_alloc_if #(
    parameter int IDX_W = 5,
    parameter int NUM   = 32
);
    localparam int CNT_W = $clog2(NUM + 1);

    logic             dec_en;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_vld;
    logic [NUM-1:0]   dec_onehot;
    logic             dec_err;

    logic             alloc_req;
    logic             alloc_gnt;
    logic [IDX_W-1:0] alloc_idx;
    logic [NUM-1:0]   alloc_onehot;

    logic             free_vld;
    logic [IDX_W-1:0] free_idx;
    logic             free_err;

    logic [NUM-1:0]   busy_mask;
    logic [CNT_W-1:0] busy_cnt;
    logic             full;
    logic             empty;

    // Requester side
    modport master (
        output dec_en, dec_idx, alloc_req, free_vld, free_idx,
        input  dec_vld, dec_onehot, dec_err, alloc_gnt, alloc_idx,
               alloc_onehot, free_err, busy_mask, busy_cnt, full, empty
    );

    // Decoder/allocator side
    modport slave (
        input  dec_en, dec_idx, alloc_req, free_vld, free_idx,
        output dec_vld, dec_onehot, dec_err, alloc_gnt, alloc_idx,
               alloc_onehot, free_err, busy_mask, busy_cnt, full, empty
    );
endinterface

// File: rtl/onehot_dec_alloc.sv
// Registered index-to-one-hot decoder with range check, plus a lowest-free
// one-hot slot allocator that tracks a busy mask and its population count.
module onehot_dec_alloc #(
    parameter int IDX_W = 5,
    parameter int NUM   = 32
) (
    input  logic                clk,
    input  logic                rst,
    onehot_dec_alloc_if.slave   bus
);
    localparam int          CNT_W = $clog2(NUM + 1);
    localparam logic [31:0] NUM_U = 32'(NUM);

    logic             dec_vld_q, dec_vld_d;
    logic [NUM-1:0]   dec_onehot_q, dec_onehot_d;
    logic             dec_err_q, dec_err_d;
    logic             free_err_q, free_err_d;
    logic [NUM-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

    logic             full, empty, alloc_gnt;
    logic             lowest_found;
    logic [NUM-1:0]   lowest_free_oh;
    logic [IDX_W-1:0] lowest_free_idx;
    logic [NUM-1:0]   free_oh;
    logic             legal_free;

    // Find the lowest clear bit of the registered busy mask
    always_comb begin
        lowest_found    = 1'b0;
        lowest_free_oh  = '0;
        lowest_free_idx = '0;
        for (int i = 0; i < NUM; i++) begin
            if (!lowest_found && !busy_q[i]) begin
                lowest_found      = 1'b1;
                lowest_free_oh[i] = 1'b1;
                lowest_free_idx   = IDX_W'(i);
            end
        end
    end

    assign full      = &busy_q;
    assign empty     = ~|busy_q;
    // Grant uses only the current mask, so a same-cycle free never bypasses
    assign alloc_gnt = bus.alloc_req & ~full;

    // Next-state for the decode path and the slot mask
    always_comb begin
        dec_vld_d    = bus.dec_en;
        dec_err_d    = bus.dec_en && (32'(bus.dec_idx) >= NUM_U);
        dec_onehot_d = '0;
        free_oh      = '0;
        for (int i = 0; i < NUM; i++) begin
            dec_onehot_d[i] = bus.dec_en && (32'(bus.dec_idx) == 32'(i));
            free_oh[i]      = bus.free_vld && (32'(bus.free_idx) == 32'(i));
        end
        // Out-of-range indices give an all-zero free_oh, so they are illegal too
        legal_free = |(busy_q & free_oh);
        free_err_d = bus.free_vld & ~legal_free;
        // Freed slot is busy now, so it can never equal the granted slot;
        // gating with legal_free keeps an illegal free from clearing a new grant
        busy_d     = (busy_q | (alloc_gnt ? lowest_free_oh : '0))
                     & ~(legal_free ? free_oh : '0);
        busy_cnt_d = busy_cnt_q + CNT_W'(alloc_gnt) - CNT_W'(legal_free);
    end

    // State registers; reset overrides any concurrent request
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_vld_q    <= 1'b0;
            dec_onehot_q <= '0;
            dec_err_q    <= 1'b0;
            free_err_q   <= 1'b0;
            busy_q       <= '0;
            busy_cnt_q   <= '0;
        end else begin
            dec_vld_q    <= dec_vld_d;
            dec_onehot_q <= dec_onehot_d;
            dec_err_q    <= dec_err_d;
            free_err_q   <= free_err_d;
            busy_q       <= busy_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign bus.dec_vld      = dec_vld_q;
    assign bus.dec_onehot   = dec_onehot_q;
    assign bus.dec_err      = dec_err_q;
    assign bus.free_err     = free_err_q;
    assign bus.busy_mask    = busy_q;
    assign bus.busy_cnt     = busy_cnt_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.alloc_gnt    = alloc_gnt;
    assign bus.alloc_idx    = alloc_gnt ? lowest_free_idx : '0;
    assign bus.alloc_onehot = alloc_gnt ? lowest_free_oh : '0;

    // The incrementally maintained count must track the mask exactly
    a_cnt_matches_mask: assert property (
        @(posedge clk) disable iff (rst) (32'(busy_cnt_q) == $countones(busy_q))
    );
endmodule

// File: tb/tb_onehot_dec_alloc.sv
// Bench for onehot_dec_alloc: a NUM=32 instance checked every cycle against a
// slot-array model, and a NUM=20 instance for out-of-range behaviour.
module tb_onehot_dec_alloc;
    localparam int NUM = 32;
    localparam int N20 = 20;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   started = 1'b0;

    onehot_dec_alloc_if #(.IDX_W(5), .NUM(NUM)) bus ();
    onehot_dec_alloc_if #(.IDX_W(5), .NUM(N20)) b20 ();

    onehot_dec_alloc #(.IDX_W(5), .NUM(NUM)) dut (.clk(clk), .rst(rst), .bus(bus));
    onehot_dec_alloc #(.IDX_W(5), .NUM(N20)) dut20 (.clk(clk), .rst(rst), .bus(b20));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model: one busy flag per slot ----------------
    bit m_busy[NUM];
    bit m_dec_vld;
    int m_dec_idx;   // -1 when no valid in-range decode
    bit m_dec_err;
    bit m_free_err;

    function automatic int lowest_free();
        for (int i = 0; i < NUM; i++)
            if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit free_ok();
        if (!bus.free_vld) return 1'b0;
        if (int'(bus.free_idx) >= NUM) return 1'b0;
        return m_busy[int'(bus.free_idx)];
    endfunction

    function automatic logic [NUM-1:0] onehot_of(input int k);
        logic [NUM-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM-1:0] model_mask();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int model_cnt();
        int c;
        c = 0;
        for (int i = 0; i < NUM; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit exp_gnt();
        return bus.alloc_req && (lowest_free() >= 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) m_busy[i] <= 1'b0;
            m_dec_vld  <= 1'b0;
            m_dec_idx  <= -1;
            m_dec_err  <= 1'b0;
            m_free_err <= 1'b0;
        end else begin
            m_dec_vld  <= bus.dec_en;
            m_dec_err  <= bus.dec_en && (int'(bus.dec_idx) >= NUM);
            m_dec_idx  <= (bus.dec_en && int'(bus.dec_idx) < NUM) ? int'(bus.dec_idx) : -1;
            m_free_err <= bus.free_vld && !free_ok();
            for (int i = 0; i < NUM; i++) begin
                if (exp_gnt() && i == lowest_free()) m_busy[i] <= 1'b1;
                else if (free_ok() && i == int'(bus.free_idx)) m_busy[i] <= 1'b0;
            end
        end
    end

    // Every-cycle compare of the NUM=32 instance against the model
    always @(negedge clk) begin
        if (started) begin
            chk("dec_vld", 64'(bus.dec_vld), 64'(m_dec_vld));
            chk("dec_onehot", 64'(bus.dec_onehot), 64'(onehot_of(m_dec_idx)));
            chk("dec_err", 64'(bus.dec_err), 64'(m_dec_err));
            chk("free_err", 64'(bus.free_err), 64'(m_free_err));
            chk("busy_mask", 64'(bus.busy_mask), 64'(model_mask()));
            chk("busy_cnt", 64'(bus.busy_cnt), 64'(model_cnt()));
            chk("full", 64'(bus.full), 64'(model_cnt() == NUM));
            chk("empty", 64'(bus.empty), 64'(model_cnt() == 0));
            chk("alloc_gnt", 64'(bus.alloc_gnt), 64'(exp_gnt()));
            chk("alloc_idx", 64'(bus.alloc_idx), exp_gnt() ? 64'(lowest_free()) : 64'd0);
            chk("alloc_onehot", 64'(bus.alloc_onehot),
                exp_gnt() ? 64'(onehot_of(lowest_free())) : 64'd0);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst = 1'b1;
        bus.dec_en = 0; bus.dec_idx = 0; bus.alloc_req = 0; bus.free_vld = 0; bus.free_idx = 0;
        b20.dec_en = 0; b20.dec_idx = 0; b20.alloc_req = 0; b20.free_vld = 0; b20.free_idx = 0;
        step();
        started = 1'b1;
        step();
        chk("rst_busy_mask", 64'(bus.busy_mask), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_dec_vld", 64'(bus.dec_vld), 64'd0);

        // Decode 0, 5, 31 back to back
        rst = 1'b0;
        bus.dec_en = 1; bus.dec_idx = 5'd0;
        step();
        chk("dec_idx0", 64'(bus.dec_onehot), 64'h0000_0001);
        chk("dec_idx0_vld", 64'(bus.dec_vld), 64'd1);
        bus.dec_idx = 5'd5;
        step();
        chk("dec_idx5", 64'(bus.dec_onehot), 64'h0000_0020);
        bus.dec_idx = 5'd31;
        step();
        chk("dec_idx31", 64'(bus.dec_onehot), 64'h8000_0000);
        chk("dec_idx31_err", 64'(bus.dec_err), 64'd0);
        bus.dec_en = 0;
        step();
        chk("dec_off_vld", 64'(bus.dec_vld), 64'd0);

        // Fill all 32 slots in order
        bus.alloc_req = 1;
        for (int i = 0; i < NUM; i++) begin
            #1;
            chk("fill_gnt", 64'(bus.alloc_gnt), 64'd1);
            chk("fill_idx", 64'(bus.alloc_idx), 64'(i));
            step();
        end
        #1;
        chk("full_cnt", 64'(bus.busy_cnt), 64'd32);
        chk("full_flag", 64'(bus.full), 64'd1);
        chk("full_no_gnt", 64'(bus.alloc_gnt), 64'd0);

        // Free slot 7 while full: no bypass into the same-cycle grant
        bus.free_vld = 1; bus.free_idx = 5'd7;
        #1;
        chk("nobypass_gnt", 64'(bus.alloc_gnt), 64'd0);
        step();
        bus.free_vld = 0;
        #1;
        chk("free7_mask", 64'(bus.busy_mask), 64'hFFFF_FF7F);
        chk("free7_cnt", 64'(bus.busy_cnt), 64'd31);
        chk("realloc7_idx", 64'(bus.alloc_idx), 64'd7);
        step();
        chk("refull", 64'(bus.full), 64'd1);

        // Reset mid-traffic
        bus.free_vld = 1; bus.free_idx = 5'd3; bus.dec_en = 1; rst = 1'b1;
        step();
        chk("midrst_mask", 64'(bus.busy_mask), 64'd0);
        chk("midrst_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("midrst_empty", 64'(bus.empty), 64'd1);
        chk("midrst_free_err", 64'(bus.free_err), 64'd0);
        chk("midrst_dec_vld", 64'(bus.dec_vld), 64'd0);

        // Build mask 0x0F, then free 2 with a simultaneous grant
        rst = 1'b0; bus.free_vld = 0; bus.dec_en = 0;
        repeat (4) step();
        bus.alloc_req = 0;
        #1;
        chk("mask_0f", 64'(bus.busy_mask), 64'h0000_000F);
        bus.free_vld = 1; bus.free_idx = 5'd2; bus.alloc_req = 1;
        #1;
        chk("sim_gnt_idx", 64'(bus.alloc_idx), 64'd4);
        step();
        bus.free_vld = 0; bus.alloc_req = 0;
        #1;
        chk("sim_mask", 64'(bus.busy_mask), 64'h0000_001B);
        chk("sim_cnt", 64'(bus.busy_cnt), 64'd4);
        bus.free_vld = 1; bus.free_idx = 5'd2;
        step();
        bus.free_vld = 0;
        chk("dbl_free_err", 64'(bus.free_err), 64'd1);
        chk("dbl_free_mask", 64'(bus.busy_mask), 64'h0000_001B);
        step();
        chk("free_err_clr", 64'(bus.free_err), 64'd0);

        // NUM=20 instance: out-of-range decode and free, fill to full
        b20.dec_en = 1; b20.dec_idx = 5'd25;
        step();
        chk("n20_dec25_vld", 64'(b20.dec_vld), 64'd1);
        chk("n20_dec25_oh", 64'(b20.dec_onehot), 64'd0);
        chk("n20_dec25_err", 64'(b20.dec_err), 64'd1);
        b20.dec_idx = 5'd19;
        step();
        chk("n20_dec19_oh", 64'(b20.dec_onehot), 64'h0008_0000);
        chk("n20_dec19_err", 64'(b20.dec_err), 64'd0);
        b20.dec_en = 0;
        step();
        chk("n20_dec_off", 64'(b20.dec_vld), 64'd0);
        b20.free_vld = 1; b20.free_idx = 5'd25;
        step();
        b20.free_vld = 0;
        chk("n20_free25_err", 64'(b20.free_err), 64'd1);
        chk("n20_free25_mask", 64'(b20.busy_mask), 64'd0);
        b20.alloc_req = 1;
        repeat (N20) step();
        #1;
        chk("n20_full", 64'(b20.full), 64'd1);
        chk("n20_cnt", 64'(b20.busy_cnt), 64'd20);
        chk("n20_no_gnt", 64'(b20.alloc_gnt), 64'd0);
        b20.alloc_req = 0;

        // Mixed traffic, checked by the per-cycle compare
        for (int c = 0; c < 400; c++) begin
            bus.alloc_req = 1'($urandom_range(0, 1));
            bus.free_vld  = 1'($urandom_range(0, 1));
            bus.free_idx  = 5'($urandom_range(0, 31));
            bus.dec_en    = 1'($urandom_range(0, 1));
            bus.dec_idx   = 5'($urandom_range(0, 31));
            rst           = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0; bus.alloc_req = 0; bus.free_vld = 0; bus.dec_en = 0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
